// File: rtl/mul_seq.sv
// mul_seq: shift-and-add 16-bit unsigned multiplier that sequences a shared ALU
// through ADD/SL/SR steps, with a start/busy/done handshake.
module mul_seq #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [2:0]       alu_com,
   input  logic [WIDTH-1:0] alu_y
);
   localparam logic [2:0] ALU_THA = 3'b000;
   localparam logic [2:0] ALU_SL  = 3'b100;
   localparam logic [2:0] ALU_SR  = 3'b101;
   localparam logic [2:0] ALU_ADD = 3'b110;

   typedef enum logic [2:0] {IDLE, ADD, SL, SR, DONE} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] mcand_q, mcand_d;
   logic [WIDTH-1:0] mplier_q, mplier_d;
   logic [WIDTH-1:0] result_q, result_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         acc_q    <= acc_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         result_q <= result_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      acc_d    = acc_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      result_d = result_q;
      alu_a    = '0;
      alu_b    = '0;
      alu_com  = ALU_THA;
      case (state_q)
         IDLE: if (start) begin
            mcand_d  = a_in;
            mplier_d = b_in;
            acc_d    = '0;
            state_d  = ADD;
         end
         ADD: begin
            alu_a   = acc_q;
            alu_b   = mcand_q;
            alu_com = ALU_ADD;
            // a fully consumed multiplier ends the loop early
            if (mplier_q == '0) state_d = DONE;
            else begin
               acc_d   = mplier_q[0] ? alu_y : acc_q;
               state_d = SL;
            end
         end
         SL: begin
            alu_a   = mcand_q;
            alu_com = ALU_SL;
            mcand_d = alu_y;
            state_d = SR;
         end
         SR: begin
            alu_a    = mplier_q;
            alu_com  = ALU_SR;
            mplier_d = alu_y;
            state_d  = ADD;
         end
         DONE: begin
            result_d = acc_q;
            state_d  = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign busy   = state_q != IDLE;
   assign done   = state_q == DONE;
   assign result = result_q;
endmodule

// File: tb/tb_mul_seq.sv
// tb_mul_seq: directed checks of mul_seq against hand-computed products,
// latencies and per-cycle ALU command sequences, with a behavioural ALU.
module tb_mul_seq;
   localparam logic [2:0] ALU_THA = 3'b000;
   localparam logic [2:0] ALU_SL  = 3'b100;
   localparam logic [2:0] ALU_SR  = 3'b101;
   localparam logic [2:0] ALU_ADD = 3'b110;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [15:0] a_in = '0;
   logic [15:0] b_in = '0;
   logic        busy, done;
   logic [15:0] result, alu_a, alu_b, alu_y;
   logic [2:0]  alu_com;
   int          passed = 0;
   int          total = 0;

   mul_seq #(.WIDTH(16)) dut (
      .clk(clk), .rst(rst), .start(start), .a_in(a_in), .b_in(b_in),
      .busy(busy), .done(done), .result(result),
      .alu_a(alu_a), .alu_b(alu_b), .alu_com(alu_com), .alu_y(alu_y)
   );

   always #5 clk = ~clk;

   always_comb begin
      alu_y = alu_a;
      case (alu_com)
         ALU_ADD: alu_y = alu_a + alu_b;
         ALU_SL:  alu_y = alu_a << 1;
         ALU_SR:  alu_y = alu_a >> 1;
         default: alu_y = alu_a;
      endcase
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      total++;
      if ({busy, done, result} !== 18'h0) $display("FAIL reset_outputs busy=%b done=%b result=%h want 0/0/0000", busy, done, result);
      else passed++;
      total++;
      if ({alu_com, alu_a, alu_b} !== {ALU_THA, 32'h0}) $display("FAIL reset_alu com=%b a=%h b=%h want THA/0/0", alu_com, alu_a, alu_b);
      else passed++;
      rst = 1'b0;
      tick();
   endtask

   // 7*5 walked cycle by cycle: index k is the cycle after edge k of the operation
   task automatic test_alu_map();
      logic [2:0]  ecom [0:11];
      logic [15:0] ea   [0:11];
      logic [15:0] eb   [0:11];
      ecom = '{ALU_ADD, ALU_SL, ALU_SR, ALU_ADD, ALU_SL, ALU_SR, ALU_ADD, ALU_SL, ALU_SR, ALU_ADD, ALU_THA, ALU_THA};
      ea   = '{16'd0, 16'd7, 16'd5, 16'd7, 16'd14, 16'd2, 16'd7, 16'd28, 16'd1, 16'd35, 16'd0, 16'd0};
      eb   = '{16'd7, 16'd0, 16'd0, 16'd14, 16'd0, 16'd0, 16'd28, 16'd0, 16'd0, 16'd56, 16'd0, 16'd0};
      a_in = 16'd7;
      b_in = 16'd5;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 0; k < 12; k++) begin
         total++;
         if ({alu_com, alu_a, alu_b} !== {ecom[k], ea[k], eb[k]})
            $display("FAIL alu_map[%0d] com=%b a=%h b=%h want com=%b a=%h b=%h", k, alu_com, alu_a, alu_b, ecom[k], ea[k], eb[k]);
         else passed++;
         total++;
         if ({busy, done} !== {k < 11, k == 10}) $display("FAIL handshake[%0d] busy=%b done=%b want %b/%b", k, busy, done, k < 11, k == 10);
         else passed++;
         if (k < 11) tick();
      end
      total++;
      if (result !== 16'h0023) $display("FAIL mul_7x5 result=%h want 0023", result);
      else passed++;
   endtask

   task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic [15:0] exp, input int exp_edge, input string name);
      int cnt = 0;
      a_in = a;
      b_in = b;
      start = 1'b1;
      tick();
      start = 1'b0;
      while (!done && cnt < 60) begin
         tick();
         cnt++;
      end
      total++;
      if (!done || cnt != exp_edge) $display("FAIL %s_latency done=%b edge=%0d want edge %0d", name, done, cnt, exp_edge);
      else passed++;
      tick();
      total++;
      if ({done, busy} !== 2'b00) $display("FAIL %s_pulse done=%b busy=%b want 0/0", name, done, busy);
      else passed++;
      total++;
      if (result !== exp) $display("FAIL %s_result result=%h want %h", name, result, exp);
      else passed++;
   endtask

   task automatic test_boundaries();
      run_op(16'h1234, 16'h0000, 16'h0000, 1, "mul_by_zero");
      run_op(16'hFFFF, 16'hFFFF, 16'h0001, 49, "mul_ffff");
      run_op(16'h0100, 16'h0100, 16'h0000, 28, "mul_trunc");
   endtask

   task automatic test_back_to_back();
      int cnt = 0;
      a_in = 16'd3;
      b_in = 16'd3;
      start = 1'b1;
      tick();
      tick();
      tick();
      a_in = 16'd9;
      b_in = 16'd9;
      cnt = 2;
      while (!done && cnt < 60) begin
         tick();
         cnt++;
      end
      total++;
      if (!done || cnt != 7) $display("FAIL b2b_first_latency done=%b edge=%0d want edge 7", done, cnt);
      else passed++;
      tick();
      total++;
      if ({busy, result} !== {1'b0, 16'h0009}) $display("FAIL b2b_first_result busy=%b result=%h want 0/0009", busy, result);
      else passed++;
      tick();
      total++;
      if ({busy, alu_com, alu_b} !== {1'b1, ALU_ADD, 16'd9}) $display("FAIL b2b_accept busy=%b com=%b b=%h want 1/%b/0009", busy, alu_com, alu_b, ALU_ADD);
      else passed++;
      cnt = 0;
      while (!done && cnt < 60) begin
         tick();
         cnt++;
      end
      start = 1'b0;
      total++;
      if (!done || cnt != 13) $display("FAIL b2b_second_latency done=%b edge=%0d want edge 13", done, cnt);
      else passed++;
      tick();
      total++;
      if ({busy, result} !== {1'b0, 16'h0051}) $display("FAIL b2b_second_result busy=%b result=%h want 0/0051", busy, result);
      else passed++;
   endtask

   task automatic test_async_reset();
      int pulses = 0;
      a_in = 16'd7;
      b_in = 16'd5;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      total++;
      if ({busy, alu_com} !== {1'b1, ALU_SL}) $display("FAIL rst_mid_setup busy=%b com=%b want 1/%b", busy, alu_com, ALU_SL);
      else passed++;
      rst = 1'b1;
      #1;
      total++;
      if ({busy, done, result} !== 18'h0) $display("FAIL rst_async busy=%b done=%b result=%h want 0/0/0000", busy, done, result);
      else passed++;
      tick();
      rst = 1'b0;
      for (int k = 0; k < 15; k++) begin
         tick();
         if (done || busy) pulses++;
      end
      total++;
      if (pulses != 0) $display("FAIL rst_no_done active_cycles=%0d want 0", pulses);
      else passed++;
      run_op(16'd2, 16'd3, 16'h0006, 7, "after_rst");
   endtask

   initial begin
      test_reset();
      test_alu_map();
      test_boundaries();
      test_back_to_back();
      test_async_reset();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
